switch_box_param: RTL
=====================

Name: switch_box_param

Overview:
- Parametrised successor to the fixed 4-track single-bit switch box.
- Each output track is a 4:1 mux over three neighbouring sides plus the PE output, with configurable track count and bus width.
- Each output has an optional pipeline register.
- Multi-word configuration is double-buffered: words are written to a shadow bank and applied atomically on commit, with read-back.
- Sits between tiles in the routing fabric, one instance per tile corner or edge.

Parameters:
- NUM_TRACKS, 4, tracks per side (T >= 2).
- WIDTH, 1, bits per track.
- OUT_SIDE_MASK, 4'b1111, bit s=1 enables outputs on side s; disabled sides drive 0.
- CFG_W, 32, configuration word width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_wires  in  4*T*WIDTH  track (s,t) at bits [((s*T)+t)*WIDTH +: WIDTH].
- pe_output  in  WIDTH  PE result, selectable on every output.
- out_wires  out  4*T*WIDTH  same packing as in_wires.
- config_en  in  1  write config_data into shadow word config_addr.
- config_addr  in  8  shadow word index.
- config_data  in  CFG_W  write data.
- config_commit  in  1  copy shadow bank to active bank.
- config_rd_data  out  CFG_W  active word at config_addr, registered.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high (ports clk, reset); all flops update on posedge clk.
- Field layout:
  - Output o = s*T+t owns a 3-bit field at linear config bits [3o+2:3o]: [1:0] sel, [2] reg_en.
  - NUM_WORDS = ceil(12*T/CFG_W); word w covers linear bits [w*CFG_W +: CFG_W].
  - Unused top bits are writable, stored, and ignored.
- Mux selection, for sel=k in 0..2:
  - Source side = (s+k+1) mod 4.
  - Source track = (t+s+k) mod T.
  - sel=3 selects pe_output.
- Output path:
  - reg_en=0: the output is combinational from active config and inputs, with zero latency.
  - reg_en=1: the output is the mux result registered, with one cycle of latency.
- Masked-off sides: out_wires for a masked-off side are constant 0, whatever the config.
- Config write: when config_en=1 and config_addr<NUM_WORDS, the shadow word is updated at the next edge. config_addr>=NUM_WORDS is ignored, with no side effects.
- Commit:
  - config_commit=1 sets active <= shadow at the next edge.
  - If config_en is high in the same cycle, the committed image includes that cycle's write (write-then-commit).
  - The active bank never changes except on commit or reset.
- Glitch-free commit: routing changes only at the commit edge. Pipeline registers keep their contents across the commit, so a newly registered output first shows the new-route value one cycle after commit.
- Read-back: config_rd_data <= active[config_addr] every cycle, one-cycle latency; 0 for out-of-range addresses.
- Reset values:
  - Shadow bank, active bank, pipeline flops and config_rd_data all reset to 0.
  - Active=0 routes every output (s,t) combinationally from side s+1, track t+s.
  - Reset wins over a simultaneous config_en or commit.
- Reset mid-operation: a partially written shadow image is discarded, so a commit after reset applies all zeros unless rewritten.

Decomposition:
- Package sb_pkg holds:
  - SB_NUM_SIDES=4, SB_SEL_W=2, SB_FIELD_W=3.
  - Sel encodings SB_SEL_N1/N2/N3/PE.
  - Functions sb_src_side(s,k) and sb_src_track(s,t,k,T).
  - Function sb_num_words(T,CFG_W).
- Sub-module sb_config_bank holds the shadow/active banks, write decode, commit and read-back, and exports the flat active vector.
- The top level generates the per-output mux and optional flop.

Test Plan:
- Reset, then no config -> out side 0 track 0 equals in side 1 track 0; side 1 track 0 equals in side 2 track 1; config_rd_data=0.
- Write word 0 with field o=0 = 3'b011, no commit -> out(0,0) unchanged. Commit -> out(0,0)=pe_output in the same cycle after the edge.
- Field o=5 = 3'b110 (reg_en, sel=2), T=4 -> out(1,1) follows in(0,(1+1+2)%4=0) with exactly one cycle of lag. Toggle the input each cycle to verify.
- config_en and config_commit asserted in one cycle with word 1=0xFFFF_FFFF -> active word 1 reads back 0xFFFF_FFFF two cycles later. Then write config_addr=NUM_WORDS -> no change to read-back.
- OUT_SIDE_MASK=4'b1011, any config with random inputs -> side-2 outputs are always 0; other sides route correctly.
- Write a shadow word, assert reset, then commit -> active stays all zero and outputs match the default routing.

Source files
------------

// File: rtl/sb_pkg.sv
// sb_pkg: shared definitions for the parametrised switch box.
//   - side count, select and field widths
//   - select encodings
//   - source side/track helpers for the routing pattern
//   - configuration word count helper
package sb_pkg;

  localparam int SB_NUM_SIDES = 4;
  localparam int SB_SEL_W     = 2;
  localparam int SB_FIELD_W   = 3;

  // Per-output select: three neighbouring sides, then the PE result.
  typedef enum logic [SB_SEL_W-1:0] {
    SB_SEL_N1 = 2'd0,
    SB_SEL_N2 = 2'd1,
    SB_SEL_N3 = 2'd2,
    SB_SEL_PE = 2'd3
  } sb_sel_e;

  // Side feeding an output on side s when sel = k (k in 0..2).
  function automatic int sb_src_side(input int s, input int k);
    return (s + k + 1) % SB_NUM_SIDES;
  endfunction

  // Track feeding output (s,t) when sel = k, on a side with num_tracks tracks.
  function automatic int sb_src_track(input int s, input int t, input int k,
                                      input int num_tracks);
    return (t + s + k) % num_tracks;
  endfunction

  // Words needed to hold one 3-bit field per output (4 sides x T tracks).
  function automatic int sb_num_words(input int num_tracks, input int cfg_w);
    return (SB_NUM_SIDES * SB_FIELD_W * num_tracks + cfg_w - 1) / cfg_w;
  endfunction

endpackage

// File: rtl/sb_config_bank.sv
// sb_config_bank: double-buffered configuration storage.
//   clk, reset      clock and synchronous active-high reset
//   config_en       write config_data into shadow word config_addr
//   config_addr     word index; indices >= NUM_WORDS are ignored
//   config_data     write data
//   config_commit   copy shadow bank into active bank
//   config_rd_data  registered read-back of active word config_addr (0 if out of range)
//   active_flat_o   active bank flattened, word w at [w*CFG_W +: CFG_W]
//
// The config interface has no handshake: a write or commit presented in a
// cycle always takes effect at the following edge. A write and commit in the
// same cycle commit the image including that write.
module sb_config_bank #(
  parameter int NUM_WORDS = 2,
  parameter int CFG_W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       config_en,
  input  logic [7:0]                 config_addr,
  input  logic [CFG_W-1:0]           config_data,
  input  logic                       config_commit,
  output logic [CFG_W-1:0]           config_rd_data,
  output logic [NUM_WORDS*CFG_W-1:0] active_flat_o
);

  logic [CFG_W-1:0] shadow_q [NUM_WORDS];
  logic [CFG_W-1:0] shadow_d [NUM_WORDS];
  logic [CFG_W-1:0] active_q [NUM_WORDS];
  logic [CFG_W-1:0] active_d [NUM_WORDS];
  logic [CFG_W-1:0] rd_data_q;
  logic [CFG_W-1:0] rd_data_d;

  always_comb begin
    shadow_d  = shadow_q;
    rd_data_d = '0;
    // Out-of-range addresses match no word, so they neither write nor read.
    for (int w = 0; w < NUM_WORDS; w++) begin
      if (config_en && (config_addr == 8'(w))) shadow_d[w] = config_data;
      if (config_addr == 8'(w)) rd_data_d = active_q[w];
    end
    // Commit takes the post-write shadow image.
    active_d = config_commit ? shadow_d : active_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int w = 0; w < NUM_WORDS; w++) begin
        shadow_q[w] <= '0;
        active_q[w] <= '0;
      end
      rd_data_q <= '0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign config_rd_data = rd_data_q;

  for (genvar w = 0; w < NUM_WORDS; w++) begin : g_flat
    assign active_flat_o[w*CFG_W +: CFG_W] = active_q[w];
  end

endmodule

// File: rtl/switch_box_param.sv
// switch_box_param: parametrised routing switch box.
//   clk, reset      clock and synchronous active-high reset
//   in_wires        4*T tracks of WIDTH bits, track (s,t) at [((s*T)+t)*WIDTH +: WIDTH]
//   pe_output       PE result, selectable on every output
//   out_wires       same packing as in_wires; masked-off sides drive 0
//   config_*        double-buffered configuration port (see sb_config_bank)
//
// Output o = s*T+t is controlled by active config bits [3o+2:3o]:
// [1:0] select, [2] register enable. Each output's pipeline flop loads the
// mux result every cycle, so after a commit a registered output shows one
// more old-route value before the new route appears.
module switch_box_param
  import sb_pkg::*;
#(
  parameter int         NUM_TRACKS    = 4,
  parameter int         WIDTH         = 1,
  parameter logic [3:0] OUT_SIDE_MASK = 4'b1111,
  parameter int         CFG_W         = 32
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic [SB_NUM_SIDES*NUM_TRACKS*WIDTH-1:0] in_wires,
  input  logic [WIDTH-1:0]                         pe_output,
  output logic [SB_NUM_SIDES*NUM_TRACKS*WIDTH-1:0] out_wires,
  input  logic                                     config_en,
  input  logic [7:0]                               config_addr,
  input  logic [CFG_W-1:0]                         config_data,
  input  logic                                     config_commit,
  output logic [CFG_W-1:0]                         config_rd_data
);

  localparam int T         = NUM_TRACKS;
  localparam int NUM_WORDS = sb_num_words(NUM_TRACKS, CFG_W);

  logic [NUM_WORDS*CFG_W-1:0] active_cfg;

  sb_config_bank #(
    .NUM_WORDS (NUM_WORDS),
    .CFG_W     (CFG_W)
  ) u_cfg (
    .clk            (clk),
    .reset          (reset),
    .config_en      (config_en),
    .config_addr    (config_addr),
    .config_data    (config_data),
    .config_commit  (config_commit),
    .config_rd_data (config_rd_data),
    .active_flat_o  (active_cfg)
  );

  // Padding config bits and sources of masked-off outputs are intentionally unused.
  logic unused_bits;
  assign unused_bits = ^{active_cfg, in_wires, pe_output};

  for (genvar s = 0; s < SB_NUM_SIDES; s++) begin : g_side
    for (genvar t = 0; t < T; t++) begin : g_track
      localparam int O = s * T + t;
      if (OUT_SIDE_MASK[s]) begin : g_on
        // Flat track indices of the three neighbour sources.
        localparam int I0 = sb_src_side(s, 0) * T + sb_src_track(s, t, 0, T);
        localparam int I1 = sb_src_side(s, 1) * T + sb_src_track(s, t, 1, T);
        localparam int I2 = sb_src_side(s, 2) * T + sb_src_track(s, t, 2, T);

        logic [SB_SEL_W-1:0] sel;
        logic                reg_en;
        logic [WIDTH-1:0]    pipe_d;
        logic [WIDTH-1:0]    pipe_q;

        assign sel    = active_cfg[SB_FIELD_W*O +: SB_SEL_W];
        assign reg_en = active_cfg[SB_FIELD_W*O + SB_SEL_W];

        always_comb begin
          pipe_d = pe_output;
          case (sb_sel_e'(sel))
            SB_SEL_N1: pipe_d = in_wires[I0*WIDTH +: WIDTH];
            SB_SEL_N2: pipe_d = in_wires[I1*WIDTH +: WIDTH];
            SB_SEL_N3: pipe_d = in_wires[I2*WIDTH +: WIDTH];
            default:   pipe_d = pe_output;
          endcase
        end

        always_ff @(posedge clk) begin
          if (reset) pipe_q <= '0;
          else       pipe_q <= pipe_d;
        end

        assign out_wires[O*WIDTH +: WIDTH] = reg_en ? pipe_q : pipe_d;
      end else begin : g_off
        assign out_wires[O*WIDTH +: WIDTH] = '0;
      end
    end
  end

endmodule
